// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Encodings shared by the MEM/WB stage and its data-memory access FSM.
//   - MemtoReg writeback-source encodings (2'b11 is treated as ALU).
//   - FSM state constants for the memory access controller.
//   - is_word_aligned(): word alignment test on a byte address.
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  function automatic logic is_word_aligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
//   Request/acknowledge data-memory bus used by the MEM stage.
//   dmem_req   : access request, held until dmem_ack or abort
//   dmem_we    : 1 = write, 0 = read (valid while dmem_req)
//   dmem_addr  : word-aligned byte address (valid while dmem_req)
//   dmem_wdata : store data (valid while dmem_req)
//   dmem_rdata : read data, meaningful only in the dmem_ack cycle
//   dmem_ack   : one-cycle completion strobe from the memory
//   Modports: master = pipeline side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_wb_stage_mem_access_fsm.sv
// ---------------------------------------------------------------------------
// mem_access_fsm
//   Controls one load/store at a time over the req/ack bus.
//   Inputs : clk, reset (sync, active-high), addr/wdata (from EX/MEM),
//            mem_read, mem_write.
//   Bus    : dmem (master modport) - request fields are registered here.
//   Outputs: stall          comb, holds the front pipeline
//            wb_load        comb, WB registers take the current instruction
//                           (otherwise the WB stage receives a bubble)
//            use_rdata      comb, the bus read data is valid this cycle
//            misalign_err   registered one-cycle pulse
//            bus_timeout_err registered one-cycle pulse
// ---------------------------------------------------------------------------
module mem_access_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 mem_read,
  input  logic                 mem_write,
  mem_wb_stage_if.master       dmem,
  output logic                 stall,
  output logic                 wb_load,
  output logic                 use_rdata,
  output logic                 misalign_err,
  output logic                 bus_timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic mem_op, aligned, ack_valid, at_limit;
  logic start, misalign, done, expire;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    mem_op    = mem_read | mem_write;
    aligned   = is_word_aligned(addr);
    // An ack with no outstanding request (e.g. after a reset abort) is stray.
    ack_valid = dmem.dmem_ack & dmem.dmem_req;
    at_limit  = (cnt == CNT_LAST);

    start     = (state == ST_IDLE) & mem_op & aligned;
    misalign  = (state == ST_IDLE) & mem_op & ~aligned;
    done      = (state == ST_ACCESS) & ack_valid;
    // Ack wins over a coincident timeout.
    expire    = (state == ST_ACCESS) & ~ack_valid & at_limit;

    stall     = start | ((state == ST_ACCESS) & ~ack_valid & ~at_limit);
    wb_load   = ((state == ST_IDLE) & ~mem_op) | done;
    use_rdata = done;
  end

  // NOTE: sequential state uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      misalign_err    <= 1'b0;
      bus_timeout_err <= 1'b0;
    end else begin
      misalign_err    <= misalign;
      bus_timeout_err <= expire;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state           <= ST_ACCESS;
            cnt             <= '0;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_write;
            dmem.dmem_addr  <= {addr[31:2], 2'b00};
            dmem.dmem_wdata <= wdata;
          end
        end
        default: begin
          if (done || expire) begin
            state         <= ST_IDLE;
            dmem.dmem_req <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM stage plus MEM/WB pipeline register.
//   Inputs : clk, reset (sync, active-high), EX/MEM register outputs
//            (MEM_PCplus4, MEM_ALU_out, MEM_Write_register, MEM_Databus2,
//             MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg).
//   Bus    : dmem (master modport) to the data memory.
//   Outputs: mem_stall (comb) freezes PC, IF/ID, ID/EX, EX/MEM;
//            WB_Write_register / WB_RegWrite / WB_Write_data to the regfile;
//            misalign_err / bus_timeout_err one-cycle error pulses.
//   Upstream inputs are held stable while mem_stall=1 and are not re-latched.
// ---------------------------------------------------------------------------
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_PCplus4,
  input  logic [31:0] MEM_ALU_out,
  input  logic [4:0]  MEM_Write_register,
  input  logic [31:0] MEM_Databus2,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_MemtoReg,
  mem_wb_stage_if.master dmem,
  output logic        mem_stall,
  output logic [4:0]  WB_Write_register,
  output logic        WB_RegWrite,
  output logic [31:0] WB_Write_data,
  output logic        misalign_err,
  output logic        bus_timeout_err
);

  logic        wb_load;
  logic        use_rdata;
  logic [31:0] wb_data;

  mem_access_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .clk             (clk),
    .reset           (reset),
    .addr            (MEM_ALU_out),
    .wdata           (MEM_Databus2),
    .mem_read        (MEM_MemRead),
    .mem_write       (MEM_MemWrite),
    .dmem            (dmem),
    .stall           (mem_stall),
    .wb_load         (wb_load),
    .use_rdata       (use_rdata),
    .misalign_err    (misalign_err),
    .bus_timeout_err (bus_timeout_err)
  );

  // Writeback source select; memory data only exists in the ack cycle,
  // so MTR_MEM outside of it falls back to the ALU result.
  always_comb begin
    wb_data = MEM_ALU_out;
    case (MEM_MemtoReg)
      MTR_PC4: wb_data = MEM_PCplus4;
      MTR_MEM: if (use_rdata) wb_data = dmem.dmem_rdata;
      default: ;
    endcase
  end

  // A bubble only clears WB_RegWrite; the other WB fields hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      WB_Write_register <= '0;
      WB_RegWrite       <= 1'b0;
      WB_Write_data     <= '0;
    end else if (wb_load) begin
      WB_Write_register <= MEM_Write_register;
      WB_RegWrite       <= MEM_RegWrite & (MEM_Write_register != 5'd0);
      WB_Write_data     <= wb_data;
    end else begin
      WB_RegWrite       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage (TIMEOUT_CYCLES=4). Expected WB
//   results are queued when an instruction is driven and compared when the
//   instruction leaves the MEM stage; bus fields, stall length and error
//   pulses are checked against constants derived from the intended timing.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pcplus4, mem_alu_out, mem_databus2;
  logic [4:0]  mem_write_register;
  logic        mem_regwrite, mem_memread, mem_memwrite;
  logic [1:0]  mem_memtoreg;
  logic        mem_stall;
  logic [4:0]  wb_write_register;
  logic        wb_regwrite;
  logic [31:0] wb_write_data;
  logic        misalign_err, bus_timeout_err;

  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk                (clk),
    .reset              (reset),
    .MEM_PCplus4        (mem_pcplus4),
    .MEM_ALU_out        (mem_alu_out),
    .MEM_Write_register (mem_write_register),
    .MEM_Databus2       (mem_databus2),
    .MEM_RegWrite       (mem_regwrite),
    .MEM_MemRead        (mem_memread),
    .MEM_MemWrite       (mem_memwrite),
    .MEM_MemtoReg       (mem_memtoreg),
    .dmem               (bus.master),
    .mem_stall          (mem_stall),
    .WB_Write_register  (wb_write_register),
    .WB_RegWrite        (wb_regwrite),
    .WB_Write_data      (wb_write_data),
    .misalign_err       (misalign_err),
    .bus_timeout_err    (bus_timeout_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    bit          full;   // 0: bubble, only WB_RegWrite is meaningful
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] d2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] mtr);
    mem_pcplus4        = pc4;
    mem_alu_out        = alu;
    mem_databus2       = d2;
    mem_write_register = rd;
    mem_regwrite       = rw;
    mem_memread        = mr;
    mem_memwrite       = mw;
    mem_memtoreg       = mtr;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic rw, input logic [31:0] data,
                           input bit full);
    exp_t e;
    e.rd = rd; e.rw = rw; e.data = data; e.full = full;
    sb.push_back(e);
  endtask

  // Entered just after a rising edge with the instruction already driven.
  // Plays the memory: acks in ACCESS cycle number ack_dly (-1 = never).
  // Returns just after the edge on which the instruction left MEM.
  task automatic run_op(input string tag, input int ack_dly, input logic [31:0] rdata,
                        output int stalls, output int reqs, output logic we,
                        output logic [31:0] addr, output logic [31:0] wdata);
    exp_t e;
    bit   finished;
    stalls = 0; reqs = 0; we = 1'b0; addr = '0; wdata = '0; finished = 0;
    for (int cyc = 0; cyc < 50 && !finished; cyc++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        if (reqs == 0) begin
          we    = bus.dmem_we;
          addr  = bus.dmem_addr;
          wdata = bus.dmem_wdata;
        end else begin
          check({tag, "_addr_hold"}, bus.dmem_addr, addr);
        end
        if (reqs == ack_dly) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
        end
        reqs++;
      end
      #1;
      if (mem_stall) stalls++;
      else           finished = 1;
      @(posedge clk);
      #1;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'hx;
    end
    check({tag, "_done"}, 32'(finished), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_wb_rw"}, 32'(wb_regwrite), 32'(e.rw));
      if (e.full) begin
        check({tag, "_wb_rd"},   32'(wb_write_register), 32'(e.rd));
        check({tag, "_wb_data"}, wb_write_data, e.data);
      end
    end
  endtask

  int          stalls, reqs;
  logic        we;
  logic [31:0] addr, wdata;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    reset          = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, MTR_ALU);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",      32'(bus.dmem_req),      32'd0);
    check("rst_we",       32'(bus.dmem_we),       32'd0);
    check("rst_addr",     bus.dmem_addr,          32'd0);
    check("rst_wb_rw",    32'(wb_regwrite),       32'd0);
    check("rst_wb_data",  wb_write_data,          32'd0);
    check("rst_misalign", 32'(misalign_err),      32'd0);
    check("rst_timeout",  32'(bus_timeout_err),   32'd0);
    reset = 1'b0;

    // 1: ALU op, single cycle.
    drive(32'h4, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, MTR_ALU);
    expect_wb(5'd5, 1'b1, 32'h10, 1);
    run_op("alu", -1, '0, stalls, reqs, we, addr, wdata);
    check("alu_stalls", 32'(stalls), 32'd0);
    check("alu_reqs",   32'(reqs),   32'd0);

    // PC+4 select and the 2'b11 encoding falling back to ALU.
    drive(32'h88, 32'h77, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, MTR_PC4);
    expect_wb(5'd31, 1'b1, 32'h88, 1);
    run_op("pc4", -1, '0, stalls, reqs, we, addr, wdata);
    drive(32'h99, 32'hABC, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b11);
    expect_wb(5'd7, 1'b1, 32'hABC, 1);
    run_op("mtr11", -1, '0, stalls, reqs, we, addr, wdata);

    // 2: load, ack in the fourth ACCESS cycle.
    drive(32'h8, 32'h100, 32'h55, 5'd9, 1'b1, 1'b1, 1'b0, MTR_MEM);
    expect_wb(5'd9, 1'b1, 32'hDEADBEEF, 1);
    run_op("load", 3, 32'hDEADBEEF, stalls, reqs, we, addr, wdata);
    check("load_stalls", 32'(stalls), 32'd4);
    check("load_reqs",   32'(reqs),   32'd4);
    check("load_we",     32'(we),     32'd0);
    check("load_addr",   addr,        32'h100);
    check("load_req_off", 32'(bus.dmem_req), 32'd0);

    // 3: store, immediate ack.
    drive(32'hC, 32'h204, 32'h12345678, 5'd3, 1'b0, 1'b0, 1'b1, MTR_ALU);
    expect_wb(5'd3, 1'b0, 32'h0, 0);
    run_op("store", 0, '0, stalls, reqs, we, addr, wdata);
    check("store_stalls", 32'(stalls), 32'd1);
    check("store_reqs",   32'(reqs),   32'd1);
    check("store_we",     32'(we),     32'd1);
    check("store_addr",   addr,        32'h204);
    check("store_wdata",  wdata,       32'h12345678);

    // Minimum-latency load into a register.
    drive(32'h10, 32'h3FC, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, MTR_MEM);
    expect_wb(5'd12, 1'b1, 32'hCAFEF00D, 1);
    run_op("load0", 0, 32'hCAFEF00D, stalls, reqs, we, addr, wdata);
    check("load0_stalls", 32'(stalls), 32'd1);

    // 4: misaligned load.
    drive(32'h14, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, MTR_MEM);
    expect_wb(5'd4, 1'b0, 32'h0, 0);
    run_op("misal", 0, '0, stalls, reqs, we, addr, wdata);
    check("misal_reqs",   32'(reqs),         32'd0);
    check("misal_stalls", 32'(stalls),       32'd0);
    check("misal_pulse",  32'(misalign_err), 32'd1);
    drive(32'h18, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, MTR_ALU);
    @(posedge clk); #1;
    check("misal_once",   32'(misalign_err), 32'd0);

    // 5: timeout after 4 ACCESS cycles, then a stray ack.
    drive(32'h1C, 32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, MTR_MEM);
    expect_wb(5'd6, 1'b0, 32'h0, 0);
    run_op("tmo", -1, '0, stalls, reqs, we, addr, wdata);
    check("tmo_reqs",    32'(reqs),            32'd4);
    check("tmo_stalls",  32'(stalls),          32'd4);
    check("tmo_pulse",   32'(bus_timeout_err), 32'd1);
    check("tmo_req_off", 32'(bus.dmem_req),    32'd0);
    drive(32'h20, 32'h5A5A, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, MTR_MEM);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hBAD0BAD0;
    expect_wb(5'd2, 1'b1, 32'h5A5A, 1);
    run_op("stray", -1, '0, stalls, reqs, we, addr, wdata);
    check("tmo_once",     32'(bus_timeout_err), 32'd0);
    check("stray_reqs",   32'(reqs),            32'd0);
    check("stray_stalls", 32'(stalls),          32'd0);

    // 6: reset in the middle of an access, then jal writing $zero.
    drive(32'h24, 32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, MTR_MEM);
    repeat (2) @(posedge clk);
    #1;
    check("mid_req",   32'(bus.dmem_req), 32'd1);
    check("mid_stall", 32'(mem_stall),    32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst2_req",     32'(bus.dmem_req),      32'd0);
    check("rst2_wb_rd",   32'(wb_write_register), 32'd0);
    check("rst2_wb_data", wb_write_data,          32'd0);
    reset          = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h11111111;
    drive(32'h40, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, MTR_PC4);
    expect_wb(5'd0, 1'b0, 32'h40, 1);
    run_op("jal", -1, '0, stalls, reqs, we, addr, wdata);
    check("jal_reqs",   32'(reqs),   32'd0);
    check("jal_stalls", 32'(stalls), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
